// File: rtl/hdmi_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pattern_gen
// Brief    : Eight-mode RGB565 test-pattern generator, two-stage pipeline
//            aligned with the incoming video timing.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_pattern_gen #(
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int X_W         = 11,
    parameter int BAR_NUM     = 16,
    parameter int MOVE_STEP   = 4,
    parameter int MOVE_W      = 64,
    parameter int AUTO_FRAMES = 120,
    parameter int SYNC_POL    = 1
) (
    input  logic           rgb_clk,
    input  logic           rgb_rst_n,
    input  logic [2:0]     mode_sel,
    input  logic           auto_cycle,
    input  logic           in_hs,
    input  logic           in_vs,
    input  logic           in_de,
    input  logic [X_W-1:0] in_x,
    input  logic [X_W-1:0] in_y,
    output logic           out_hs,
    output logic           out_vs,
    output logic           out_de,
    output logic [15:0]    out_data,
    output logic [2:0]     cur_mode
);

    localparam int c_BAR_W = H_ACTIVE / BAR_NUM;
    localparam int c_PX_W  = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;
    localparam int c_BI_W  = (BAR_NUM > 1) ? $clog2(BAR_NUM) : 1;
    localparam int c_FC_W  = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    localparam logic              c_SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [c_PX_W-1:0] c_PX_LAST  = c_PX_W'(c_BAR_W - 1);
    localparam logic [c_BI_W-1:0] c_BI_LAST  = c_BI_W'(BAR_NUM - 1);
    localparam logic [c_FC_W-1:0] c_FC_LAST  = c_FC_W'(AUTO_FRAMES - 1);
    localparam logic [X_W-1:0]    c_X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0]    c_Y_LAST   = X_W'(V_ACTIVE - 1);

    logic              r_vs_prev;
    logic [X_W-1:0]    r_pos;
    logic [c_FC_W-1:0] r_frame_cnt;
    logic [c_PX_W-1:0] r_px_cnt;
    logic [c_BI_W-1:0] r_bar_idx;
    logic [2:0]        r_cur_mode;

    logic              r_s1_hs;
    logic              r_s1_vs;
    logic              r_s1_de;
    logic [X_W-1:0]    r_s1_x;
    logic [X_W-1:0]    r_s1_y;
    logic [c_BI_W-1:0] r_s1_bar;
    logic [2:0]        r_s1_mode;

    logic              w_boundary;
    logic [31:0]       w_pos_sum;
    logic [3:0]        w_bar_lo;
    logic [5:0]        w_g6;
    logic [31:0]       w_x32;
    logic [31:0]       w_pos32;
    logic              w_in_bar;
    logic              w_on_border;
    logic [15:0]       w_pattern;

    assign w_boundary = (in_vs == c_SYNC_ACT) && (r_vs_prev != c_SYNC_ACT);
    assign w_pos_sum  = 32'(r_pos) + 32'(MOVE_STEP);
    assign cur_mode   = r_cur_mode;

    // Frame-rate state: moving-bar position and mode selection
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_vs_prev   <= ~c_SYNC_ACT;
            r_pos       <= '0;
            r_frame_cnt <= '0;
            r_cur_mode  <= 3'd0;
        end else begin
            r_vs_prev <= in_vs;
            if (w_boundary) begin
                r_pos <= (w_pos_sum >= 32'(H_ACTIVE)) ? '0 : X_W'(w_pos_sum);
                if (!auto_cycle) begin
                    r_cur_mode  <= mode_sel;
                    r_frame_cnt <= '0;
                end else if (r_frame_cnt == c_FC_LAST) begin
                    r_frame_cnt <= '0;
                    r_cur_mode  <= r_cur_mode + 3'd1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
                end
            end
        end
    end

    // Remainder pixels past the last full bar stay in the final bar
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_px_cnt  <= '0;
            r_bar_idx <= '0;
        end else if (!in_de) begin
            r_px_cnt  <= '0;
            r_bar_idx <= '0;
        end else if (r_px_cnt == c_PX_LAST) begin
            r_px_cnt <= '0;
            if (r_bar_idx != c_BI_LAST) begin
                r_bar_idx <= r_bar_idx + c_BI_W'(1);
            end
        end else begin
            r_px_cnt <= r_px_cnt + c_PX_W'(1);
        end
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_s1_hs   <= ~c_SYNC_ACT;
            r_s1_vs   <= ~c_SYNC_ACT;
            r_s1_de   <= 1'b0;
            r_s1_x    <= '0;
            r_s1_y    <= '0;
            r_s1_bar  <= '0;
            r_s1_mode <= 3'd0;
        end else begin
            r_s1_hs   <= in_hs;
            r_s1_vs   <= in_vs;
            r_s1_de   <= in_de;
            r_s1_x    <= in_x;
            r_s1_y    <= in_y;
            r_s1_bar  <= r_bar_idx;
            r_s1_mode <= r_cur_mode;
        end
    end

    generate
        if (c_BI_W >= 4) begin : g_bar_lo_wide
            assign w_bar_lo = r_s1_bar[3:0];
        end else begin : g_bar_lo_narrow
            assign w_bar_lo = 4'(r_s1_bar);
        end
    endgenerate

    assign w_g6        = r_s1_x[X_W-1 -: 6];
    assign w_x32       = 32'(r_s1_x);
    assign w_pos32     = 32'(r_pos);
    assign w_in_bar    = (w_x32 >= w_pos32) && (w_x32 < w_pos32 + 32'(MOVE_W));
    assign w_on_border = (r_s1_x == '0) || (r_s1_x == c_X_LAST) ||
                         (r_s1_y == '0) || (r_s1_y == c_Y_LAST);

    always_comb begin
        w_pattern = 16'h0000;
        case (r_s1_mode)
            3'd0:    w_pattern = 16'h8000 >> w_bar_lo;
            3'd1:    w_pattern = {w_g6[5:1], w_g6, w_g6[5:1]};
            3'd2:    w_pattern = (r_s1_x[5] ^ r_s1_y[5]) ? 16'h0000 : 16'hFFFF;
            3'd3:    w_pattern = w_in_bar ? 16'hFFFF : 16'h0000;
            3'd4:    w_pattern = w_on_border ? 16'hFFFF : 16'h001F;
            3'd5:    w_pattern = 16'hF800;
            3'd6:    w_pattern = 16'h07E0;
            default: w_pattern = 16'h001F;
        endcase
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            out_hs   <= ~c_SYNC_ACT;
            out_vs   <= ~c_SYNC_ACT;
            out_de   <= 1'b0;
            out_data <= 16'h0000;
        end else begin
            out_hs   <= r_s1_hs;
            out_vs   <= r_s1_vs;
            out_de   <= r_s1_de;
            out_data <= r_s1_de ? w_pattern : 16'h0000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_pattern_gen
// Brief    : Directed vector bench for hdmi_pattern_gen (default instance plus
//            a narrow H_ACTIVE=100 / AUTO_FRAMES=2 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_pattern_gen;

    logic        rgb_clk   = 1'b0;
    logic        rgb_rst_n = 1'b0;
    logic [2:0]  mode_sel  = 3'd0;
    logic        auto_cycle = 1'b0;
    logic        in_hs = 1'b0;
    logic        in_vs = 1'b0;
    logic        in_de = 1'b0;
    logic [10:0] in_x  = '0;
    logic [10:0] in_y  = '0;

    logic        out_hs, out_vs, out_de;
    logic [15:0] out_data;
    logic [2:0]  cur_mode;
    logic        b_hs, b_vs, b_de;
    logic [15:0] b_data;
    logic [2:0]  b_mode;

    hdmi_pattern_gen u_dut (
        .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n), .mode_sel(mode_sel),
        .auto_cycle(auto_cycle), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .in_x(in_x), .in_y(in_y), .out_hs(out_hs), .out_vs(out_vs),
        .out_de(out_de), .out_data(out_data), .cur_mode(cur_mode)
    );

    hdmi_pattern_gen #(.H_ACTIVE(100), .BAR_NUM(16), .AUTO_FRAMES(2)) u_dut_b (
        .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n), .mode_sel(mode_sel),
        .auto_cycle(auto_cycle), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .in_x(in_x), .in_y(in_y), .out_hs(b_hs), .out_vs(b_vs),
        .out_de(b_de), .out_data(b_data), .cur_mode(b_mode)
    );

    always #5 rgb_clk = ~rgb_clk;

    typedef struct {
        logic [2:0]  mode;
        int          y;
        int          x;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[21];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] cap  [0:2047];
    logic [15:0] cap2 [0:2047];
    logic        h_hs[2], h_vs[2], h_de[2];
    int          h_x[2];
    int          hcnt = 0;
    logic [2:0]  cur_sel;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One pixel clock: check the output belonging to the input driven two
    // clocks earlier, then drive the next input.
    task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
        @(negedge rgb_clk);
        if (!rgb_rst_n) begin
            hcnt = 0;
        end else begin
            if (hcnt >= 2) begin
                chk("out_hs_align", 16'(out_hs), 16'(h_hs[1]));
                chk("out_vs_align", 16'(out_vs), 16'(h_vs[1]));
                chk("out_de_align", 16'(out_de), 16'(h_de[1]));
                chk("b_de_align",   16'(b_de),   16'(h_de[1]));
                if (h_de[1]) begin
                    cap[h_x[1]]  = out_data;
                    cap2[h_x[1]] = b_data;
                end else begin
                    chk("out_data_blank", out_data, 16'h0000);
                end
            end else begin
                hcnt++;
            end
        end
        h_hs[1] = h_hs[0]; h_vs[1] = h_vs[0]; h_de[1] = h_de[0]; h_x[1] = h_x[0];
        h_hs[0] = hs;      h_vs[0] = vs;      h_de[0] = de;      h_x[0] = x;
        in_hs = hs; in_vs = vs; in_de = de; in_x = 11'(x); in_y = 11'(y);
    endtask

    task automatic run_line(input int y, input int nx);
        for (int i = 0; i < 2048; i++) begin
            cap[i]  = 16'hDEAD;
            cap2[i] = 16'hDEAD;
        end
        for (int i = 0; i < nx; i++) step(1'b0, 1'b0, 1'b1, i, y);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic frame_start();
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 0,    0,    16'h8000};
        vecs[1]  = '{3'd0, 0,    119,  16'h8000};
        vecs[2]  = '{3'd0, 0,    120,  16'h4000};
        vecs[3]  = '{3'd0, 0,    1919, 16'h0001};
        vecs[4]  = '{3'd1, 0,    0,    16'h0000};
        vecs[5]  = '{3'd1, 0,    1024, 16'h8410};
        vecs[6]  = '{3'd1, 0,    1919, 16'hEF7D};
        vecs[7]  = '{3'd2, 0,    0,    16'hFFFF};
        vecs[8]  = '{3'd2, 0,    32,   16'h0000};
        vecs[9]  = '{3'd2, 32,   32,   16'hFFFF};
        vecs[10] = '{3'd2, 32,   0,    16'h0000};
        vecs[11] = '{3'd4, 0,    5,    16'hFFFF};
        vecs[12] = '{3'd4, 5,    0,    16'hFFFF};
        vecs[13] = '{3'd4, 5,    5,    16'h001F};
        vecs[14] = '{3'd4, 5,    1919, 16'hFFFF};
        vecs[15] = '{3'd4, 1079, 5,    16'hFFFF};
        vecs[16] = '{3'd4, 1078, 1918, 16'h001F};
        vecs[17] = '{3'd5, 3,    7,    16'hF800};
        vecs[18] = '{3'd6, 3,    7,    16'h07E0};
        vecs[19] = '{3'd7, 3,    7,    16'h001F};
        vecs[20] = '{3'd7, 0,    1919, 16'h001F};

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst_out_hs", 16'(out_hs), 16'h0);
        chk("rst_out_vs", 16'(out_vs), 16'h0);
        chk("rst_out_de", 16'(out_de), 16'h0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_cur_mode", 16'(cur_mode), 16'h0);
        rgb_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);

        // Narrow instance: BAR_W = 6 with a saturated last bar
        run_line(0, 100);
        chk("b_bar0_x0",   cap2[0],  16'h8000);
        chk("b_bar1_x6",   cap2[6],  16'h4000);
        chk("b_bar14_x89", cap2[89], 16'h0002);
        chk("b_sat_x90",   cap2[90], 16'h0001);
        chk("b_sat_x99",   cap2[99], 16'h0001);
        chk("a_bar0_x99",  cap[99],  16'h8000);

        // Vector table
        cur_sel = 3'd0;
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].mode != cur_sel) begin
                cur_sel  = vecs[i].mode;
                mode_sel = cur_sel;
                frame_start();
            end
            run_line(vecs[i].y, vecs[i].x + 1);
            chk($sformatf("vec%0d_data", i), cap[vecs[i].x], vecs[i].exp);
            chk($sformatf("vec%0d_mode", i), 16'(cur_mode), 16'(vecs[i].mode));
        end

        // Mid-frame mode_sel change is deferred to the next boundary
        mode_sel = 3'd0;
        frame_start();
        run_line(10, 40);
        mode_sel = 3'd2;
        run_line(500, 130);
        chk("midframe_x0",   cap[0],   16'h8000);
        chk("midframe_x125", cap[125], 16'h4000);
        chk("midframe_mode", 16'(cur_mode), 16'h0);
        frame_start();
        chk("switch_mode", 16'(cur_mode), 16'h2);
        run_line(0, 64);
        chk("chk_x0_y0",  cap[0],  16'hFFFF);
        chk("chk_x32_y0", cap[32], 16'h0000);
        run_line(32, 64);
        chk("chk_x32_y32", cap[32], 16'hFFFF);

        // Asynchronous reset in the middle of a mode-1 line
        mode_sel = 3'd1;
        frame_start();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1, i, 3);
        chk("pre_rst_data", out_data, 16'h0020);
        #2 rgb_rst_n = 1'b0;
        #1;
        chk("arst_out_hs", 16'(out_hs), 16'h0);
        chk("arst_out_vs", 16'(out_vs), 16'h0);
        chk("arst_out_de", 16'(out_de), 16'h0);
        chk("arst_out_data", out_data, 16'h0000);
        chk("arst_cur_mode", 16'(cur_mode), 16'h0);
        chk("arst_b_mode", 16'(b_mode), 16'h0);
        in_de = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        rgb_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        run_line(1, 1920);
        chk("post_rst_x0",    cap[0],    16'h8000);
        chk("post_rst_x240",  cap[240],  16'h2000);
        chk("post_rst_x1919", cap[1919], 16'h0001);
        mode_sel = 3'd5;
        run_line(2, 10);
        chk("post_rst_still0", cap[5], 16'h8000);
        frame_start();
        run_line(2, 10);
        chk("post_rst_mode5", cap[5], 16'hF800);

        // Moving bar: boundary k since reset gives pos = 4k
        mode_sel = 3'd3;
        frame_start();
        run_line(0, 80);
        chk("mv8_x7",  cap[7],  16'h0000);
        chk("mv8_x8",  cap[8],  16'hFFFF);
        chk("mv8_x71", cap[71], 16'hFFFF);
        chk("mv8_x72", cap[72], 16'h0000);
        for (int k = 3; k <= 479; k++) frame_start();
        run_line(0, 1920);
        chk("mv1916_x1915", cap[1915], 16'h0000);
        chk("mv1916_x1916", cap[1916], 16'hFFFF);
        chk("mv1916_x1919", cap[1919], 16'hFFFF);
        frame_start();
        run_line(0, 70);
        chk("mvwrap_x0",  cap[0],  16'hFFFF);
        chk("mvwrap_x63", cap[63], 16'hFFFF);
        chk("mvwrap_x64", cap[64], 16'h0000);

        // Auto-cycle: narrow instance steps every 2 frames, default every 120
        auto_cycle = 1'b0;
        mode_sel   = 3'd0;
        frame_start();
        chk("auto_setup_a", 16'(cur_mode), 16'h0);
        chk("auto_setup_b", 16'(b_mode), 16'h0);
        auto_cycle = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            mode_sel = 3'(j * 3);
            frame_start();
            chk($sformatf("auto_b_j%0d", j), 16'(b_mode), 16'((j / 2) % 8));
            chk($sformatf("auto_a_j%0d", j), 16'(cur_mode), 16'h0);
        end

        // auto_cycle dropped in the very boundary cycle governs that boundary
        step(1'b0, 1'b1, 1'b0, 0, 0);
        auto_cycle = 1'b0;
        mode_sel   = 3'd6;
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("toggle_a_mode", 16'(cur_mode), 16'h6);
        chk("toggle_b_mode", 16'(b_mode), 16'h6);
        run_line(0, 10);
        chk("toggle_b_data", cap2[3], 16'h07E0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
